// File: rtl/mst_str_chk_pkg.sv
// Shared definitions for the stream checker: FSM encoding, byte-enable
// constant and counter width.
package mst_str_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam logic [3:0] BE_ALL = 4'hf;
  localparam int         CNT_W  = 16;

endpackage

// File: rtl/mst_str_fifo.sv
// Small receive FIFO for the stream checker. The read address is derived
// from the write pointer and fill length, so no read pointer is kept.
module mst_str_fifo #(
  parameter int ADDRBIT = 2,
  parameter int LENGTH  = 4,
  parameter int WIDTH   = 36
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [WIDTH-1:0]   din,
  input  logic               rd,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic [ADDRBIT:0]   length
);

  logic [LENGTH-1:0][WIDTH-1:0] mem;
  logic [ADDRBIT-1:0]           wrptr;
  logic [ADDRBIT-1:0]           rdaddr;
  logic                         full;
  logic                         do_wr;
  logic                         do_rd;

  assign full   = length[ADDRBIT];
  assign empty  = (length == '0);
  assign do_wr  = wr && !full;
  assign do_rd  = rd && !empty;
  // Oldest entry sits 'length' slots behind the write pointer.
  assign rdaddr = wrptr - length[ADDRBIT-1:0];
  assign dout   = mem[rdaddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wrptr  <= '0;
      length <= '0;
    end else begin
      if (do_wr) begin
        mem[wrptr] <= din;
        wrptr      <= wrptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   length <= length + 1'b1;
        2'b01:   length <= length - 1'b1;
        default: length <= length;
      endcase
    end
  end

endmodule

// File: rtl/mst_str_chk.sv
// Receive-side incrementing-pattern checker: buffers words, compares each
// against a running expected value and keeps match/error statistics.
module mst_str_chk
  import mst_str_chk_pkg::*;
#(
  parameter int ADDRBIT = 2,
  parameter int LENGTH  = 4,
  parameter int WIDTH   = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             postena,
  input  logic             chkclr,
  input  logic             postwr,
  input  logic [WIDTH-1:0] postdin,
  output logic             postnfull,
  output logic             chk0err,
  output logic [CNT_W-1:0] chk0cnt,
  output logic [CNT_W-1:0] chk0errcnt
);

  localparam int DW = WIDTH - 4;
  localparam logic [ADDRBIT:0] NFULL_LIM = (ADDRBIT+1)'(LENGTH - 1);

  state_t           state, state_nx;
  logic             empty;
  logic             rd;
  logic [ADDRBIT:0] length;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] cmp_word;
  logic             cmp_vld;
  logic             cmp;
  logic             match;
  logic [DW-1:0]    chkexp;

  assign rd = (state != IDLE) && !empty;

  mst_str_fifo #(.ADDRBIT(ADDRBIT), .LENGTH(LENGTH), .WIDTH(WIDTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (postwr),
    .din    (postdin),
    .rd     (rd),
    .dout   (rd_word),
    .empty  (empty),
    .length (length)
  );

  // Threshold one below full covers a writer whose strobe lags by a cycle.
  assign postnfull = (length < NFULL_LIM);

  assign cmp   = cmp_vld && !chkclr;
  assign match = (cmp_word[WIDTH-1 -: 4] == BE_ALL) && (cmp_word[DW-1:0] == chkexp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_vld  <= 1'b0;
      cmp_word <= '0;
    end else begin
      cmp_vld <= rd;
      if (rd) cmp_word <= rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chkexp     <= '0;
      chk0cnt    <= '0;
      chk0errcnt <= '0;
      chk0err    <= 1'b0;
    end else if (chkclr) begin
      chkexp     <= '0;
      chk0cnt    <= '0;
      chk0errcnt <= '0;
      chk0err    <= 1'b0;
    end else if (cmp) begin
      chk0cnt <= chk0cnt + 1'b1;
      if (match) begin
        chkexp <= chkexp + 1'b1;
      end else begin
        chkexp  <= cmp_word[DW-1:0] + 1'b1;
        chk0err <= 1'b1;
        if (chk0errcnt != '1) chk0errcnt <= chk0errcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!postena) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     if (cmp && !match) state_nx = FAIL;
        FAIL:    if (chkclr) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mst_str_chk.sv
// Directed bench for mst_str_chk: stimulus pushes expected per-compare
// statistics into a queue, a monitor pops them as the word count advances.
module tb_mst_str_chk;
  import mst_str_chk_pkg::*;

  localparam int ADDRBIT = 2;
  localparam int LENGTH  = 4;
  localparam int WIDTH   = 36;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             postena;
  logic             chkclr;
  logic             postwr;
  logic [WIDTH-1:0] postdin;
  logic             postnfull;
  logic             chk0err;
  logic [15:0]      chk0cnt;
  logic [15:0]      chk0errcnt;

  mst_str_chk #(.ADDRBIT(ADDRBIT), .LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .postena    (postena),
    .chkclr     (chkclr),
    .postwr     (postwr),
    .postdin    (postdin),
    .postnfull  (postnfull),
    .chk0err    (chk0err),
    .chk0cnt    (chk0cnt),
    .chk0errcnt (chk0errcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit err;
    int errcnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nfull_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input int cnt, input bit err, input int errcnt);
    exp_t e;
    e.cnt = cnt; e.err = err; e.errcnt = errcnt;
    q.push_back(e);
  endtask

  // Monitor: each +1 step of chk0cnt is one compared word.
  initial begin : monitor
    logic [15:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && chk0cnt !== last) begin
        if (chk0cnt == 16'd0) begin
          last = '0;
        end else if (chk0cnt != last + 16'd1) begin
          check("cnt_step", 32'(chk0cnt), 32'(last + 16'd1));
          last = chk0cnt;
        end else if (q.size() == 0) begin
          check("unexpected_compare", 32'(chk0cnt), 32'(last));
          last = chk0cnt;
        end else begin
          e = q.pop_front();
          check("sb_cnt",    32'(chk0cnt),    32'(e.cnt));
          check("sb_err",    32'(chk0err),    32'(e.err));
          check("sb_errcnt", 32'(chk0errcnt), 32'(e.errcnt));
          last = chk0cnt;
        end
      end
    end
  end

  task automatic put(input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    postwr  = 1'b1;
    postdin = {be, d};
  endtask

  task automatic idle();
    @(negedge clk);
    postwr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nfull"},  32'(postnfull),  32'd1);
    check({tag, "_err"},    32'(chk0err),    32'd0);
    check({tag, "_cnt"},    32'(chk0cnt),    32'd0);
    check({tag, "_errcnt"}, 32'(chk0errcnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n  = 1'b0;
    postwr = 1'b0;
    #2;
    check_reset_outputs(tag);
    check({tag, "_len"},   32'(dut.u_fifo.length), 32'd0);
    check({tag, "_state"}, 32'(dut.state),         32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; postena = 1'b0; chkclr = 1'b0; postwr = 1'b0; postdin = '0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream 0..7, writer paced by postnfull.
    @(negedge clk);
    postena = 1'b1;
    nfull_low = 0;
    for (int i = 0; i < 8; i++) exp_push(i + 1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int k = 0; k < 10 && !postnfull; k++) begin
        nfull_low++;
        postwr = 1'b0;
        @(negedge clk);
      end
      postwr  = 1'b1;
      postdin = {4'hf, 32'(i)};
    end
    idle();
    drain();
    check("s1_cnt",       32'(chk0cnt), 32'd8);
    check("s1_err",       32'(chk0err), 32'd0);
    check("s1_nfull_low", 32'(nfull_low), 32'd0);

    // Fill while idle: fifth word dropped.
    do_reset("r2");
    postena = 1'b0;
    for (int i = 0; i < 5; i++) put(4'hf, 32'(i));
    idle();
    check("s2_len",   32'(dut.u_fifo.length), 32'd4);
    check("s2_nfull", 32'(postnfull),         32'd0);
    check("s2_cnt",   32'(chk0cnt),           32'd0);
    for (int i = 0; i < 4; i++) exp_push(i + 1, 1'b0, 0);
    postena = 1'b1;
    drain();
    check("s2_cnt4",  32'(chk0cnt),   32'd4);
    check("s2_state", 32'(dut.state), 32'(RUN));
    check("s2_nfull1", 32'(postnfull), 32'd1);
    exp_push(5, 1'b0, 0);
    put(4'hf, 32'd4);
    idle();
    drain();

    // Gap in sequence: one error, then resync.
    do_reset("r3");
    postena = 1'b1;
    exp_push(1, 1'b0, 0);
    exp_push(2, 1'b0, 0);
    exp_push(3, 1'b0, 0);
    exp_push(4, 1'b1, 1);
    exp_push(5, 1'b1, 1);
    put(4'hf, 32'd0); put(4'hf, 32'd1); put(4'hf, 32'd2);
    put(4'hf, 32'd7); put(4'hf, 32'd8);
    idle();
    drain();
    check("s3_errcnt", 32'(chk0errcnt), 32'd1);
    check("s3_state",  32'(dut.state),  32'(FAIL));

    // Partial byte enables, then clear.
    do_reset("r4");
    postena = 1'b1;
    exp_push(1, 1'b1, 1);
    put(4'h7, 32'd0);
    idle();
    drain();
    check("s4_err", 32'(chk0err), 32'd1);
    @(negedge clk); chkclr = 1'b1;
    @(negedge clk); chkclr = 1'b0;
    check("s4_clr_err",    32'(chk0err),    32'd0);
    check("s4_clr_cnt",    32'(chk0cnt),    32'd0);
    check("s4_clr_errcnt", 32'(chk0errcnt), 32'd0);
    check("s4_clr_state",  32'(dut.state),  32'(RUN));
    exp_push(1, 1'b0, 0);
    put(4'hf, 32'd0);
    idle();
    drain();

    // Reset with buffered words.
    do_reset("r5");
    postena = 1'b0;
    put(4'hf, 32'd5); put(4'hf, 32'd6); put(4'hf, 32'd7);
    idle();
    check("s5_len3", 32'(dut.u_fifo.length), 32'd3);
    do_reset("r5b");
    check("s5_len0", 32'(dut.u_fifo.length), 32'd0);
    postena = 1'b1;
    exp_push(1, 1'b0, 0);
    exp_push(2, 1'b0, 0);
    put(4'hf, 32'd0); put(4'hf, 32'd1);
    idle();
    drain();
    check("s5_cnt", 32'(chk0cnt), 32'd2);
    check("s5_err", 32'(chk0err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
